// File: rtl/lab5_wsum_seq.sv
// Sequential weighted sum: one shared signed multiplier walks the channels,
// then the floored, saturated result is held until downstream accepts it.
module lab5_wsum_seq #(
  parameter int N_CH = 3,
  parameter int XW   = 10,
  parameter int KW   = 12,
  parameter int KF   = 11,
  parameter int YW   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_CH*XW-1:0] x_flat,
  input  logic               k_we,
  input  logic [3:0]         k_addr,
  input  logic [KW-1:0]      k_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [YW-1:0]      y,
  output logic               sat
);

  localparam int AW = XW + KW + $clog2(N_CH) + 1;
  localparam logic [3:0] LAST = 4'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [XW-1:0]  x_q [16];
  logic signed [XW-1:0]  x_d [16];
  logic signed [KW-1:0]  k_q [16];
  logic signed [KW-1:0]  k_d [16];
  logic signed [YW-1:0]  y_q, y_d;
  logic                  sat_q, sat_d;
  logic                  ov_q, ov_d;

  logic signed [XW+KW-1:0] prod;
  logic signed [AW-1:0]    acc_sum;
  logic [YW:0]             clip_res;

  // Power-on taps reproduce the original fixed (-0.5, 0.625, -0.5) filter.
  function automatic logic signed [KW-1:0] k_reset(input int i);
    case (i)
      0, 2:    return KW'(12'shC00);
      1:       return KW'(12'sh500);
      default: return '0;
    endcase
  endfunction

  // Returns {sat, y}: saturate when the bits above the output sign are not
  // all copies of it.
  function automatic logic [YW:0] sat_clip(input logic signed [AW-1:0] v);
    logic [AW-YW:0] top;
    top = v[AW-1:YW-1];
    if (&top || ~|top) return {1'b0, v[YW-1:0]};
    else if (v[AW-1])  return {1'b1, 1'b1, {(YW-1){1'b0}}};
    else               return {1'b1, 1'b0, {(YW-1){1'b1}}};
  endfunction

  assign prod     = x_q[idx_q] * k_q[idx_q];
  assign acc_sum  = acc_q + AW'(prod);
  assign clip_res = sat_clip(acc_sum >>> KF);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    x_d     = x_q;
    k_d     = k_q;
    y_d     = y_q;
    sat_d   = sat_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (k_we && ({1'b0, k_addr} < 5'(N_CH))) k_d[k_addr] = k_wdata;
        if (in_valid) begin
          for (int i = 0; i < N_CH; i++) x_d[i] = x_flat[i*XW +: XW];
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (idx_q == LAST) begin
          y_d     = clip_res[YW-1:0];
          sat_d   = clip_res[YW];
          ov_d    = 1'b1;
          state_d = OUT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        x_q[i] <= '0;
        k_q[i] <= k_reset(i);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      x_q     <= x_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign y         = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_lab5_wsum_seq.sv
// Directed bench for lab5_wsum_seq: vector table plus hand-written sequences
// for back-pressure, ignored coefficient writes and mid-computation reset.
module tb_lab5_wsum_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] x_flat;
  logic        k_we;
  logic [3:0]  k_addr;
  logic [11:0] k_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  y;
  logic        sat;

  int checks = 0;
  int errors = 0;

  lab5_wsum_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_flat(x_flat), .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [11:0] k0, k1, k2;
    int          x0, x1, x2;
    int          ey;
    int          es;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_k(input logic [3:0] a, input logic [11:0] d);
    k_we = 1'b1; k_addr = a; k_wdata = d;
    tick();
    k_we = 1'b0;
  endtask

  function automatic logic [29:0] pack_x(input int a, input int b, input int c);
    logic [9:0] xa, xb, xc;
    xa = 10'(a); xb = 10'(b); xc = 10'(c);
    return {xc, xb, xa};
  endfunction

  task automatic wait_ov(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int cyc;
    if (v.wr) begin
      write_k(4'd0, v.k0);
      write_k(4'd1, v.k1);
      write_k(4'd2, v.k2);
    end
    out_ready = 1'b1;
    x_flat    = pack_x(v.x0, v.x1, v.x2);
    in_valid  = 1'b1;
    chk({nm, " in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    wait_ov(cyc);
    chk({nm, " latency"}, cyc, 3);
    chk({nm, " y"}, int'($signed(y)), v.ey);
    chk({nm, " sat"}, int'(sat), v.es);
    tick();
    chk({nm, " ov_drop"}, int'(out_valid), 0);
    chk({nm, " idle"}, int'(in_ready), 1);
  endtask

  initial begin
    int cyc;
    int bad;
    vecs[0] = '{1'b0, 12'hC00, 12'h500, 12'hC00,  100,  200,  100,   25, 0};
    vecs[1] = '{1'b1, 12'h7FF, 12'h7FF, 12'h7FF,  511,  511,  511,  511, 1};
    vecs[2] = '{1'b1, 12'h800, 12'h800, 12'h800,  511,  511,  511, -512, 1};
    vecs[3] = '{1'b1, 12'hC00, 12'h000, 12'h000,    1,    0,    0,   -1, 0};
    vecs[4] = '{1'b1, 12'h400, 12'h400, 12'h400, -100,   50,    7,  -22, 0};
    vecs[5] = '{1'b1, 12'hC00, 12'h500, 12'hC00, -512, -512, -512,  192, 0};
    vecs[6] = '{1'b1, 12'h7FF, 12'h000, 12'h000,  511,    0,    0,  510, 0};
    vecs[7] = '{1'b1, 12'h800, 12'h000, 12'h000, -512,    0,    0,  511, 1};
    vecs[8] = '{1'b1, 12'h800, 12'h000, 12'h000,  511,    0,    0, -511, 0};

    rst_n = 1'b1; in_valid = 1'b0; x_flat = '0; k_we = 1'b0;
    k_addr = '0; k_wdata = '0; out_ready = 1'b1;
    tick();
    do_reset();
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst y", int'(y), 0);
    chk("rst sat", int'(sat), 0);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: result held, new input ignored while in OUT.
    do_reset();
    out_ready = 1'b0;
    x_flat = pack_x(100, 200, 100);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov(cyc);
    chk("bp latency", cyc, 3);
    x_flat = pack_x(-7, 300, 5);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp y", int'($signed(y)), 25);
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp release ov", int'(out_valid), 0);
    chk("bp release idle", int'(in_ready), 1);

    // Coefficient writes during MAC and to an out-of-range index are ignored.
    x_flat = pack_x(100, 200, 100);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k_we = 1'b1; k_addr = 4'd1; k_wdata = 12'h000;
    tick();
    tick();
    k_we = 1'b0;
    wait_ov(cyc);
    chk("kwe_mac y", int'($signed(y)), 25);
    tick();
    write_k(4'd5, 12'h000);
    run_vec("kwe_ign", vecs[0]);

    // Same-edge write and accept: new coefficient applies to this vector.
    k_we = 1'b1; k_addr = 4'd1; k_wdata = 12'h000;
    x_flat = pack_x(100, 200, 100);
    in_valid = 1'b1;
    tick();
    k_we = 1'b0; in_valid = 1'b0;
    wait_ov(cyc);
    chk("same_edge y", int'($signed(y)), -100);
    tick();

    // Reset during MAC abandons the vector and restores the coefficients.
    x_flat = pack_x(100, 200, 100);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    do_reset();
    chk("mac_rst in_ready", int'(in_ready), 1);
    chk("mac_rst ov", int'(out_valid), 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) bad++;
      tick();
    end
    chk("mac_rst no_pulse", bad, 0);
    run_vec("mac_rst coef", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab5_wsum_seq.md
LAB5_WSUM_SEQ -- requirements
Module: lab5_wsum_seq

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of input channels and coefficients (1..16).
REQ-002 SHALL have parameter XW, default 10: signed input sample width.
REQ-003 SHALL have parameter KW, default 12: signed coefficient width.
REQ-004 SHALL have parameter KF, default 11: coefficient fraction bits (1.11 at defaults).
REQ-005 SHALL have parameter YW, default 10: signed output width.
REQ-006 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port in_valid, input, 1: x_flat holds a valid sample vector.
REQ-009 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-010 SHALL have port x_flat, input, N_CH*XW: channel i at bits [i*XW +: XW], signed.
REQ-011 SHALL have port k_we, input, 1: coefficient write strobe.
REQ-012 SHALL have port k_addr, input, 4: coefficient index.
REQ-013 SHALL have port k_wdata, input, KW: signed coefficient value.
REQ-014 SHALL have port out_valid, output, 1: y is valid.
REQ-015 SHALL have port out_ready, input, 1: downstream accepts y.
REQ-016 SHALL have port y, output, YW: signed result.
REQ-017 SHALL have port sat, output, 1: y was clipped; qualified by out_valid.

Function
REQ-018 SHALL compute y = clip(floor(sum over i of x[i]*k[i] / 2^KF)) to the signed YW range, with full-precision accumulation (accumulator width XW+KW+ceil(log2(N_CH))+1).
REQ-019 SHALL use exactly one XW x KW signed multiplier, time-shared across channels.
REQ-020 SHALL implement FSM states IDLE, MAC, OUT.
REQ-021 SHALL assert in_ready only in IDLE.
REQ-022 SHALL, in IDLE on in_valid=1, register x_flat, clear the accumulator, set the channel index to 0, and go to MAC.
REQ-023 SHALL, in MAC, add x[idx]*k[idx] per cycle, with idx running 0..N_CH-1.
REQ-024 SHALL, on the edge that adds channel N_CH-1, register y and sat, set out_valid=1, and go to OUT, so that out_valid rises N_CH edges after the accept edge.
REQ-025 SHALL, in OUT, hold y, sat, and out_valid=1 stable while out_ready=0.
REQ-026 SHALL, in OUT on out_ready=1, clear out_valid and go to IDLE; the next vector is acceptable one cycle later (no bypass).
REQ-027 SHALL set sat=1 and clip y to 2^(YW-1)-1 or -2^(YW-1) when the scaled sum exceeds the range.
REQ-028 SHALL perform floor rounding (arithmetic shift; truncation toward minus infinity).
REQ-029 SHALL write k[k_addr] <= k_wdata on k_we=1 only in IDLE with k_addr < N_CH.
REQ-030 SHALL ignore k_we outside IDLE and k_we with k_addr >= N_CH, leaving state unchanged.
REQ-031 SHALL, when k_we and an in_valid accept occur on the same IDLE edge, apply the write and use the new coefficient for that vector.
REQ-032 SHALL ignore x_flat and in_valid outside IDLE.

Reset
REQ-033 SHALL, on rst_n=0 at a clock edge, set state IDLE, out_valid=0, y=0, sat=0, accumulator=0, and idx=0 (in_ready=1 after reset).
REQ-034 SHALL reset k[0]=0xC00, k[1]=0x500, and k[2]=0xC00, and all other k[i]=0 (at defaults, reproduces the fixed three-tap datapath).
REQ-035 SHALL, on reset asserted in MAC or OUT, abandon the computation with no out_valid pulse; reset dominates all other inputs.

Verification
REQ-036 SHALL verify: defaults, reset coefficients, x=(100,200,100), out_ready=1 -> out_valid 3 cycles after accept, y=25, sat=0.
REQ-037 SHALL verify: write k0..k2=0x7FF, x=(511,511,511) -> y=511, sat=1; then k0..k2=0x800 -> y=-512, sat=1.
REQ-038 SHALL verify: k0=0xC00, k1=k2=0, x=(1,0,0) -> y=-1 (floor of -0.5), sat=0.
REQ-039 SHALL verify: out_ready=0 for 5 cycles after out_valid -> y/out_valid stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-040 SHALL verify: k_we to k_addr=1 during MAC, and k_addr=5 in IDLE -> no coefficient change; repeat scenario REQ-036 -> y=25.
REQ-041 SHALL verify: rst_n=0 for one edge during MAC -> no out_valid, in_ready=1 next cycle, coefficients restored to reset values.
